lex_stream: RTL and testbench

- Hardware tokenizer: consumes a byte stream of C-subset source text and emits one classified token per handshake.
- Token classes: reserved operator or keyword, identifier, decimal number, end-of-file.
- Sits upstream of the hardware statement parser and produces exactly the token stream that parser consumes.

---
 rtl/lex_stream.sv | 216 +++++++++++++++++++++
 tb/tb_lex_stream.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/lex_stream.sv
// lex_stream: byte-stream tokenizer for a C subset, one classified token per output handshake.
// Optional build macro LEX_COMMENT_EN adds skipping of // line and /* block */ comments.
module lex_stream #(
  parameter int NUM_W    = 32,
  parameter int NAME_MAX = 8,
  parameter int POS_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0]            in_char,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [1:0]            out_kind,
  output logic [4:0]            out_code,
  output logic [NUM_W-1:0]      out_num,
  output logic [NAME_MAX*8-1:0] out_name,
  output logic [3:0]            out_len,
  output logic [POS_W-1:0]      out_pos,
  output logic                  err
);
  localparam int NAME_W = NAME_MAX * 8;
  localparam logic [3:0] LEN_MAX = 4'(NAME_MAX);

  typedef enum logic [1:0] {K_RES, K_IDENT, K_NUM, K_EOF} kind_t;
  typedef enum logic [3:0] {S_IDLE, S_NUM, S_IDENT, S_OP2, S_EMIT, S_EOF
`ifdef LEX_COMMENT_EN
    , S_SLASH, S_LCMT, S_BCMT, S_BSTAR
`endif
  } state_t;

  state_t            state, ns;
  logic [POS_W-1:0]  pos, pos_inc, tok_pos, hold_pos, b_pos;
  logic              hold_valid, hold_last, final_tok, trunc;
  logic [7:0]        hold_char, op_char, b;
  logic [NUM_W-1:0]  acc, acc_app, dig;
  logic [NAME_W-1:0] name, name_app, id_name;
  logic [3:0]        len, len_app, id_len;
  logic [4:0]        id_kw;
  logic              fire_in, proc, b_last;
  logic              is_digit, is_alpha, is_ws, is_op2;
  logic              emit_now, eof_now, hold_now, err_now;
  kind_t             e_kind;
  logic [4:0]        e_code;
  logic [NUM_W-1:0]  e_num;
  logic [NAME_W-1:0] e_name;
  logic [3:0]        e_len;
  logic [POS_W-1:0]  e_pos;

  function automatic logic [4:0] single_code(input logic [7:0] c);
    case (c)
      "+": return 5'd1;   "-": return 5'd2;   "*": return 5'd3;   "/": return 5'd4;
      "(": return 5'd5;   ")": return 5'd6;   "<": return 5'd7;   ">": return 5'd8;
      "=": return 5'd9;   ";": return 5'd10;  "{": return 5'd11;  "}": return 5'd12;
      default: return 5'd0;
    endcase
  endfunction

  function automatic logic [4:0] two_code(input logic [7:0] c);
    case (c)
      "=": return 5'd13;  "!": return 5'd14;  "<": return 5'd15;
      default: return 5'd16;
    endcase
  endfunction

  // Names are stored first-char-lowest, so keyword literals are spelled reversed.
  function automatic logic [4:0] kw_code(input logic [NAME_W-1:0] nm, input logic [3:0] ln);
    if (ln == 4'd6 && nm == NAME_W'("nruter")) return 5'd17;
    if (ln == 4'd2 && nm == NAME_W'("fi"))     return 5'd18;
    if (ln == 4'd4 && nm == NAME_W'("esle"))   return 5'd19;
    if (ln == 4'd3 && nm == NAME_W'("rof"))    return 5'd20;
    if (ln == 4'd5 && nm == NAME_W'("elihw"))  return 5'd21;
    return 5'd0;
  endfunction

  assign in_ready = !out_valid && !hold_valid && state != S_EOF;
  assign fire_in  = in_valid && in_ready;
  // A held terminator is replayed before any new input byte.
  assign proc     = (hold_valid && !out_valid) || fire_in;
  assign b        = hold_valid ? hold_char : in_char;
  assign b_last   = hold_valid ? hold_last : in_last;
  assign b_pos    = hold_valid ? hold_pos  : pos;
  assign pos_inc  = pos + POS_W'(1);

  assign is_digit = (b >= "0") && (b <= "9");
  assign is_alpha = (b >= "a" && b <= "z") || (b >= "A" && b <= "Z") || b == "_";
  assign is_ws    = b == " " || b == 8'h09 || b == 8'h0A || b == 8'h0D;
  assign is_op2   = b == "=" || b == "!" || b == "<" || b == ">";

  assign dig      = NUM_W'(b - 8'h30);
  assign acc_app  = acc * NUM_W'(10) + dig;
  assign name_app = (len < LEN_MAX) ? (name | (NAME_W'(b) << {len, 3'b000})) : name;
  assign len_app  = (len < LEN_MAX) ? len + 4'd1 : len;
  assign id_name  = (is_alpha || is_digit) ? name_app : name;
  assign id_len   = (is_alpha || is_digit) ? len_app : len;
  assign id_kw    = kw_code(id_name, id_len);

  always_comb begin
    emit_now = 1'b0; eof_now = 1'b0; hold_now = 1'b0; err_now = 1'b0; ns = state;
    e_kind = K_RES; e_code = '0; e_num = '0; e_name = '0; e_len = '0; e_pos = tok_pos;
    if (proc) begin
      case (state)
        S_IDLE: begin
          e_pos = b_pos;
          if (is_ws) eof_now = b_last;
          else if (is_digit) begin
            if (b_last) begin emit_now = 1'b1; e_kind = K_NUM; e_num = dig; end
            else ns = S_NUM;
          end else if (is_alpha) begin
            if (b_last) begin emit_now = 1'b1; e_kind = K_IDENT; e_name = NAME_W'(b); e_len = 4'd1; end
            else ns = S_IDENT;
          end else if (is_op2) begin
            if (!b_last) ns = S_OP2;
            else if (b == "!") begin err_now = 1'b1; eof_now = 1'b1; end
            else begin emit_now = 1'b1; e_code = single_code(b); end
          end
`ifdef LEX_COMMENT_EN
          else if (b == "/" && !b_last) ns = S_SLASH;
`endif
          else if (single_code(b) != 5'd0) begin emit_now = 1'b1; e_code = single_code(b); end
          else begin err_now = 1'b1; eof_now = b_last; end
        end
        S_NUM: begin
          if (!is_digit) begin emit_now = 1'b1; hold_now = 1'b1; e_kind = K_NUM; e_num = acc; end
          else if (b_last) begin emit_now = 1'b1; e_kind = K_NUM; e_num = acc_app; end
        end
        S_IDENT: begin
          if (is_alpha || is_digit) err_now = (len == LEN_MAX) && !trunc;
          if (!(is_alpha || is_digit) || b_last) begin
            emit_now = 1'b1;
            hold_now = !(is_alpha || is_digit);
            if (id_kw != 5'd0) e_code = id_kw;
            else begin e_kind = K_IDENT; e_name = id_name; e_len = id_len; end
          end
        end
        S_OP2: begin
          if (b == "=") begin emit_now = 1'b1; e_code = two_code(op_char); end
          else if (op_char == "!") begin err_now = 1'b1; hold_now = 1'b1; ns = S_IDLE; end
          else begin emit_now = 1'b1; hold_now = 1'b1; e_code = single_code(op_char); end
        end
`ifdef LEX_COMMENT_EN
        S_SLASH: begin
          if (b == "/") begin ns = S_LCMT; eof_now = b_last; end
          else if (b == "*") begin ns = S_BCMT; err_now = b_last; eof_now = b_last; end
          else begin emit_now = 1'b1; hold_now = 1'b1; e_code = 5'd4; end
        end
        S_LCMT: begin
          if (b == 8'h0A) ns = S_IDLE;
          eof_now = b_last;
        end
        S_BCMT: begin
          if (b == "*") ns = S_BSTAR;
          err_now = b_last; eof_now = b_last;
        end
        S_BSTAR: begin
          if (b == "/") begin ns = S_IDLE; eof_now = b_last; end
          else begin ns = (b == "*") ? S_BSTAR : S_BCMT; err_now = b_last; eof_now = b_last; end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;  out_valid <= 1'b0; out_kind <= '0; out_code <= '0; out_num <= '0;
      out_name <= '0;   out_len <= '0;     out_pos <= '0;  err <= 1'b0;    pos <= '0;
      hold_valid <= 1'b0; hold_char <= '0; hold_last <= 1'b0; hold_pos <= '0;
      final_tok <= 1'b0;  acc <= '0; name <= '0; len <= '0; trunc <= 1'b0;
      tok_pos <= '0;      op_char <= '0;
    end else begin
      err <= 1'b0;
      if (fire_in) pos <= pos_inc;
      case (state)
        S_EMIT: if (out_ready) begin
          if (final_tok) begin
            state <= S_EOF; out_kind <= K_EOF; out_code <= '0; out_num <= '0;
            out_name <= '0; out_len <= '0; out_pos <= pos;
          end else begin
            state <= S_IDLE; out_valid <= 1'b0;
          end
        end
        S_EOF: if (out_ready) begin
          state <= S_IDLE; out_valid <= 1'b0; pos <= '0;
        end
        default: if (proc) begin
          err        <= err_now;
          hold_valid <= hold_now;
          if (hold_now) begin hold_char <= b; hold_last <= b_last; hold_pos <= b_pos; end
          if (emit_now) begin
            state <= S_EMIT; out_valid <= 1'b1; out_kind <= e_kind; out_code <= e_code;
            out_num <= e_num; out_name <= e_name; out_len <= e_len; out_pos <= e_pos;
            final_tok <= b_last && !hold_now;
          end else if (eof_now) begin
            state <= S_EOF; out_valid <= 1'b1; out_kind <= K_EOF; out_code <= '0; out_num <= '0;
            out_name <= '0; out_len <= '0; out_pos <= fire_in ? pos_inc : pos;
          end else begin
            state <= ns;
          end
          if (state == S_IDLE) begin
            tok_pos <= b_pos; op_char <= b; acc <= dig;
            name <= NAME_W'(b); len <= 4'd1; trunc <= 1'b0;
          end
          if (state == S_NUM) acc <= acc_app;
          if (state == S_IDENT && (is_alpha || is_digit)) begin
            name <= name_app; len <= len_app;
            if (len == LEN_MAX) trunc <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lex_stream.sv
// tb_lex_stream: directed token-stream vectors with hand-computed expected tokens for lex_stream.
// Comment-skipping vectors are included only when LEX_COMMENT_EN is defined.
module tb_lex_stream;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_char = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [1:0]  out_kind;
  logic [4:0]  out_code;
  logic [31:0] out_num;
  logic [63:0] out_name;
  logic [3:0]  out_len;
  logic [15:0] out_pos;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [1:0]  kind;
    logic [4:0]  code;
    logic [31:0] num;
    logic [63:0] name;
    logic [3:0]  len;
    logic [15:0] pos;
  } tok_t;
  tok_t exp_q[$];

  lex_stream #(.NUM_W(32), .NAME_MAX(8), .POS_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
    .out_code(out_code), .out_num(out_num), .out_name(out_name), .out_len(out_len),
    .out_pos(out_pos), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void add(input logic [1:0] k, input logic [4:0] c, input logic [31:0] n,
                              input string nm, input logic [15:0] p);
    tok_t t;
    t.kind = k; t.code = c; t.num = n; t.name = '0; t.len = 4'(nm.len()); t.pos = p;
    for (int i = 0; i < nm.len(); i++) t.name[i*8 +: 8] = nm[i];
    exp_q.push_back(t);
  endfunction

  function automatic void e_res(input logic [4:0] c, input logic [15:0] p); add(2'd0, c, 0, "", p); endfunction
  function automatic void e_id(input string nm, input logic [15:0] p); add(2'd1, 5'd0, 0, nm, p); endfunction
  function automatic void e_num(input logic [31:0] v, input logic [15:0] p); add(2'd2, 5'd0, v, "", p); endfunction
  function automatic void e_eof(input logic [15:0] p); add(2'd3, 5'd0, 0, "", p); endfunction

  // Feeds s (in_last on its final byte), holds out_ready low for the stall cycle count on the
  // first token, and compares every accepted token and the err pulse count.
  task automatic run(input string tag, input string s, input int stall, input int exp_err);
    int idx = 0, ntok = 0, errs = 0, stall_left = stall, cyc = 0;
    bit done = 0, snap_ok = 0;
    logic [63:0] snap_a, snap_n;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (err) errs++;
      in_valid  = (idx < s.len());
      in_char   = in_valid ? s[idx] : 8'h00;
      in_last   = in_valid && (idx == s.len() - 1);
      out_ready = (stall_left == 0);
      if (out_valid && !out_ready) begin
        stall_left--;
        if (!snap_ok) begin
          snap_a  = {5'd0, out_kind, out_code, out_len, out_pos, out_num};
          snap_n  = out_name;
          snap_ok = 1;
        end else begin
          check($sformatf("%s stall fields", tag), {5'd0, out_kind, out_code, out_len, out_pos, out_num}, snap_a);
          check($sformatf("%s stall name", tag), out_name, snap_n);
          check($sformatf("%s stall in_ready", tag), 64'(in_ready), 64'd0);
        end
      end
      if (in_valid && in_ready) idx++;
      if (out_valid && out_ready) begin
        if (ntok < exp_q.size()) begin
          check($sformatf("%s t%0d kind", tag, ntok), 64'(out_kind), 64'(exp_q[ntok].kind));
          check($sformatf("%s t%0d code", tag, ntok), 64'(out_code), 64'(exp_q[ntok].code));
          check($sformatf("%s t%0d num", tag, ntok), 64'(out_num), 64'(exp_q[ntok].num));
          check($sformatf("%s t%0d name", tag, ntok), out_name, exp_q[ntok].name);
          check($sformatf("%s t%0d len", tag, ntok), 64'(out_len), 64'(exp_q[ntok].len));
          check($sformatf("%s t%0d pos", tag, ntok), 64'(out_pos), 64'(exp_q[ntok].pos));
        end else begin
          check($sformatf("%s extra token", tag), 64'(ntok), 64'(exp_q.size()));
        end
        ntok++;
        if (out_kind == 2'd3) done = 1;
      end
    end
    if (!done) check($sformatf("%s timeout", tag), 64'd1, 64'd0);
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (err) errs++;
    end
    check($sformatf("%s token count", tag), 64'(ntok), 64'(exp_q.size()));
    check($sformatf("%s err count", tag), 64'(errs), 64'(exp_err));
    exp_q.delete();
  endtask

  initial begin
    #3;
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset err", 64'(err), 64'd0);
    check("reset kind", 64'(out_kind), 64'd0);
    check("reset pos", 64'(out_pos), 64'd0);
    check("reset in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    e_id("a", 0); e_res(9, 1); e_num(3, 2); e_res(10, 3); e_eof(4);
    run("assign", "a=3;", 0, 0);

    e_id("x", 0); e_res(15, 1); e_num(10, 3); e_res(14, 5); e_id("y", 7); e_eof(8);
    run("ops", "x<=10!=y", 0, 0);

    e_res(18, 0); e_res(5, 2); e_id("ifx", 3); e_res(6, 6); e_res(17, 7);
    e_num(42, 14); e_res(10, 16); e_eof(17);
    run("kw", "if(ifx)return 42;", 0, 0);

    e_id("abcdefgh", 0); e_eof(10);
    run("longid", "abcdefghij", 5, 1);

    e_num(1, 0); e_eof(10);
    run("wrap", "4294967297", 0, 0);

    e_num(12, 0); e_id("ab", 2); e_eof(4);
    run("split", "12ab", 0, 0);

    e_eof(1);
    run("bad", "#", 0, 1);

    e_num(8, 0); e_res(4, 1); e_num(2, 2); e_eof(5);
    run("div_bang", "8/2 !", 0, 1);

    e_id("return1", 0); e_res(19, 8); e_res(11, 12); e_res(12, 13); e_eof(14);
    run("else", "return1 else{}", 0, 0);

    e_res(21, 0); e_res(5, 5); e_res(20, 6); e_res(16, 9); e_id("a", 11); e_res(6, 12); e_eof(13);
    run("while", "while(for>=a)", 0, 0);

    e_id("p", 0); e_res(7, 1); e_id("q", 2); e_res(16, 3); e_res(3, 5); e_res(1, 6); e_res(2, 7); e_eof(8);
    run("arith", "p<q>=*+-", 0, 0);

`ifdef LEX_COMMENT_EN
    e_num(1, 0); e_res(4, 5); e_num(2, 6); e_eof(12);
    run("comment", $sformatf("1//c%c/2/*z*/", 8'h0A), 0, 0);

    e_eof(2);
    run("open_cmt", "/*", 0, 1);
`endif

    @(negedge clk);
    in_valid = 1'b1; in_char = "a"; in_last = 1'b0;
    @(negedge clk);
    in_char = "b";
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst out_valid", 64'(out_valid), 64'd0);
    check("midrst in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    e_num(7, 0); e_eof(1);
    run("after_rst", "7", 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
